// File: rtl/serial_operand_recover.sv
// Bit-serial operand recovery: given Z and B, rebuilds A (Z-B when CALC=0, Z+B when CALC=1),
// one bit per clock LSB first, behind valid/ready handshakes on both sides.
module serial_operand_recover #(
   parameter int unsigned CALC  = 0,
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] DIN_Z,
   input  logic [WIDTH-1:0] DIN_B,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] DOUT,
   output logic             DOUT_C
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_z;
   logic [WIDTH-1:0] r_b;
   logic [CW-1:0]    r_cnt;
   logic             r_cy;

   logic [WIDTH-1:0] w_z_nxt;
   logic [WIDTH-1:0] w_b_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_cy_nxt;
   logic [WIDTH-1:0] w_dout_nxt;
   logic             w_dout_c_nxt;
   logic             w_in_ready_nxt;
   logic             w_out_valid_nxt;

   logic             w_zb;
   logic             w_bit;
   logic             w_cy_step;

   // One full-adder / full-subtractor slice on the current LSBs
   assign w_zb  = r_z[0] ^ r_b[0];
   assign w_bit = w_zb ^ r_cy;

   if (CALC == 0) begin : g_sub
      assign w_cy_step = (~r_z[0] & r_b[0]) | (~w_zb & r_cy);
   end else begin : g_add
      assign w_cy_step = (r_z[0] & r_b[0]) | (r_cy & w_zb);
   end

   // State and datapath register
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_z       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_cy      <= 1'b0;
         DOUT      <= '0;
         DOUT_C    <= 1'b0;
         IN_READY  <= 1'b1;
         OUT_VALID <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_z       <= w_z_nxt;
         r_b       <= w_b_nxt;
         r_cnt     <= w_cnt_nxt;
         r_cy      <= w_cy_nxt;
         DOUT      <= w_dout_nxt;
         DOUT_C    <= w_dout_c_nxt;
         IN_READY  <= w_in_ready_nxt;
         OUT_VALID <= w_out_valid_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_z_nxt         = r_z;
      w_b_nxt         = r_b;
      w_cnt_nxt       = r_cnt;
      w_cy_nxt        = r_cy;
      w_dout_nxt      = DOUT;
      w_dout_c_nxt    = DOUT_C;
      w_in_ready_nxt  = 1'b0;
      w_out_valid_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (IN_VALID) begin
               w_z_nxt     = DIN_Z;
               w_b_nxt     = DIN_B;
               w_cnt_nxt   = '0;
               w_cy_nxt    = 1'b0;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_z_nxt    = {1'b0, r_z[WIDTH-1:1]};
            w_b_nxt    = {1'b0, r_b[WIDTH-1:1]};
            w_cy_nxt   = w_cy_step;
            w_dout_nxt = {w_bit, DOUT[WIDTH-1:1]};
            w_cnt_nxt  = r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
               w_dout_c_nxt = w_cy_step;
               w_state_nxt  = S_DONE;
            end
         end
         S_DONE: begin
            if (OUT_READY) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_in_ready_nxt  = (w_state_nxt == S_IDLE);
      w_out_valid_nxt = (w_state_nxt == S_DONE);
   end

endmodule

// File: tb/tb_serial_operand_recover.sv
// Bench for serial_operand_recover: four instances (sub/add at 8 and 4 bits) checked against
// an arithmetic reference and a forward add/sub model for round trips.
`timescale 1ns/1ps
module tb_serial_operand_recover;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv   [4];
   logic        ordy [4];
   logic [31:0] dz   [4];
   logic [31:0] db   [4];
   logic [3:0]  ir;
   logic [3:0]  ov;
   logic [3:0]  dc;
   logic [7:0]  dq0;
   logic [7:0]  dq1;
   logic [3:0]  dq2;
   logic [3:0]  dq3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_operand_recover #(.CALC(0), .WIDTH(8)) u_sub8 (
      .CLK(clk), .RST(rst), .IN_VALID(iv[0]), .IN_READY(ir[0]),
      .DIN_Z(dz[0][7:0]), .DIN_B(db[0][7:0]), .OUT_VALID(ov[0]),
      .OUT_READY(ordy[0]), .DOUT(dq0), .DOUT_C(dc[0]));

   serial_operand_recover #(.CALC(1), .WIDTH(8)) u_add8 (
      .CLK(clk), .RST(rst), .IN_VALID(iv[1]), .IN_READY(ir[1]),
      .DIN_Z(dz[1][7:0]), .DIN_B(db[1][7:0]), .OUT_VALID(ov[1]),
      .OUT_READY(ordy[1]), .DOUT(dq1), .DOUT_C(dc[1]));

   serial_operand_recover #(.CALC(0), .WIDTH(4)) u_sub4 (
      .CLK(clk), .RST(rst), .IN_VALID(iv[2]), .IN_READY(ir[2]),
      .DIN_Z(dz[2][3:0]), .DIN_B(db[2][3:0]), .OUT_VALID(ov[2]),
      .OUT_READY(ordy[2]), .DOUT(dq2), .DOUT_C(dc[2]));

   serial_operand_recover #(.CALC(1), .WIDTH(4)) u_add4 (
      .CLK(clk), .RST(rst), .IN_VALID(iv[3]), .IN_READY(ir[3]),
      .DIN_Z(dz[3][3:0]), .DIN_B(db[3][3:0]), .OUT_VALID(ov[3]),
      .OUT_READY(ordy[3]), .DOUT(dq3), .DOUT_C(dc[3]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int wid(input int u);
      return (u < 2) ? 8 : 4;
   endfunction

   function automatic int calc(input int u);
      return u % 2;
   endfunction

   function automatic logic [31:0] mask(input int u);
      return (32'd1 << wid(u)) - 32'd1;
   endfunction

   function automatic logic [31:0] get_dout(input int u);
      case (u)
         0:       return 32'(dq0);
         1:       return 32'(dq1);
         2:       return 32'(dq2);
         default: return 32'(dq3);
      endcase
   endfunction

   // Reference: inverse operation on plain integers
   task automatic ref_inverse(input int u, input logic [31:0] z, input logic [31:0] b,
                              output logic [31:0] d, output logic c);
      longint s;
      if (calc(u) == 0) begin
         s = longint'(z) - longint'(b);
         d = 32'(s) & mask(u);
         c = (z < b);
      end else begin
         s = longint'(z) + longint'(b);
         d = 32'(s) & mask(u);
         c = ((s >> wid(u)) & 64'd1) != 0;
      end
   endtask

   // Forward add/sub datapath feeding the block
   function automatic logic [31:0] fwd(input int u, input logic [31:0] a, input logic [31:0] b);
      if (calc(u) == 0) return (a + b) & mask(u);
      else              return (a - b) & mask(u);
   endfunction

   task automatic do_op(input int u, input logic [31:0] zz, input logic [31:0] bb,
                        input int stall, input bit hold_v,
                        input logic [31:0] exp_d, input logic exp_c, input string tag);
      int          lat;
      bit          seen;
      bit          ready_lo;
      bit          stable;
      logic [31:0] d0;
      logic        c0;
      check_val({tag, "/idle_ready"}, 32'(ir[u]), 32'd1);
      dz[u] = zz; db[u] = bb; iv[u] = 1'b1; ordy[u] = 1'b0;
      @(posedge clk); #1;
      if (!hold_v) iv[u] = 1'b0;
      ready_lo = !ir[u] && !ov[u];
      lat = 0; seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk); #1;
         lat++;
         if (hold_v) begin dz[u] = $urandom; db[u] = $urandom; end
         if (ir[u]) ready_lo = 0;
         if (ov[u]) seen = 1;
      end
      check_val({tag, "/latency"}, 32'(lat), 32'(wid(u)));
      if (!seen) return;
      check_val({tag, "/busy_no_ready"}, 32'(ready_lo), 32'd1);
      check_val({tag, "/dout"}, get_dout(u), exp_d);
      check_val({tag, "/dout_c"}, 32'(dc[u]), 32'(exp_c));
      d0 = get_dout(u); c0 = dc[u]; stable = 1;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         if (!ov[u] || ir[u] || get_dout(u) !== d0 || dc[u] !== c0) stable = 0;
         if (hold_v) begin dz[u] = $urandom; db[u] = $urandom; end
      end
      if (stall > 0) check_val({tag, "/stall_stable"}, 32'(stable), 32'd1);
      ordy[u] = 1'b1;
      @(posedge clk); #1;
      check_val({tag, "/handshake_idle"}, {30'd0, ov[u], ir[u]}, 32'd1);
      ordy[u] = 1'b0; iv[u] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b, z, ed;
      logic        ec;
      bit          stale;
      rst = 1'b1;
      for (int u = 0; u < 4; u++) begin
         iv[u] = 1'b0; ordy[u] = 1'b0; dz[u] = '0; db[u] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 4; u++) begin
         check_val($sformatf("reset_flags%0d", u), {29'd0, ir[u], ov[u], dc[u]}, 32'b100);
         check_val($sformatf("reset_dout%0d", u), get_dout(u), 32'd0);
      end
      rst = 1'b0;

      do_op(0, 32'h50, 32'h20, 0, 0, 32'h30, 1'b0, "sub_basic");
      do_op(0, 32'h10, 32'h20, 0, 0, 32'hF0, 1'b1, "sub_wrap");
      do_op(0, 32'hFF, 32'hFF, 0, 0, 32'h00, 1'b0, "sub_ones");
      do_op(0, 32'h5A, 32'h00, 0, 0, 32'h5A, 1'b0, "sub_b0");
      do_op(1, 32'hF0, 32'h20, 0, 0, 32'h10, 1'b1, "add_carry");
      do_op(1, 32'h05, 32'h00, 0, 0, 32'h05, 1'b0, "add_b0");
      do_op(1, 32'hFF, 32'hFF, 0, 0, 32'hFE, 1'b1, "add_ones");
      do_op(0, 32'h33, 32'h11, 5, 1, 32'h22, 1'b0, "backpressure");
      do_op(0, 32'h40, 32'h01, 0, 0, 32'h3F, 1'b0, "after_bp");

      // Reset after three bits have been processed
      dz[0] = 32'h50; db[0] = 32'h20; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("rst_mid_flags", {29'd0, ir[0], ov[0], dc[0]}, 32'b100);
      check_val("rst_mid_dout", get_dout(0), 32'd0);
      rst = 1'b0;
      stale = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (ov[0]) stale = 1;
      end
      check_val("rst_mid_no_stale", 32'(stale), 32'd0);
      do_op(0, 32'h80, 32'h01, 0, 0, 32'h7F, 1'b0, "post_rst");

      // Round trip through the forward model with random stalls
      for (int u = 0; u < 2; u++) begin
         for (int n = 0; n < 500; n++) begin
            a = $urandom & mask(u);
            b = $urandom & mask(u);
            z = fwd(u, a, b);
            ref_inverse(u, z, b, ed, ec);
            do_op(u, z, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), a, ec,
                  $sformatf("rt%0d_a%0h_b%0h", u, a, b));
         end
      end

      // Exhaustive 4-bit round trip
      for (int u = 2; u < 4; u++) begin
         for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
               a = 32'(ai); b = 32'(bi);
               z = fwd(u, a, b);
               ref_inverse(u, z, b, ed, ec);
               do_op(u, z, b, 0, 0, a, ec, $sformatf("ex%0d_a%0h_b%0h", u, a, b));
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
